// File: rtl/loop_perf_monitor_pkg.sv
// Shared types and helpers for the HLS pipelined-loop performance monitor.
package loop_perf_pkg;

  localparam int unsigned CNT_W = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

  typedef enum logic {
    CTRL_IDLE,
    CTRL_ACTIVE
  } ctrl_state_t;

  // A stage event fires when the FSM sits in the stage state with the pipeline enabled and not stalled.
  function automatic logic ev_decode(input logic match, input logic enable, input logic block);
    return match & enable & ~block;
  endfunction

endpackage

// File: rtl/loop_perf_monitor_if.sv
// Probe inputs and monitor results; master drives probes, slave is the monitor.
interface loop_perf_monitor_if #(
  parameter int unsigned STATE_W = 32,
  parameter int unsigned CNT_W   = 32
);
  logic [STATE_W-1:0] cur_state, iter_start_state, iter_end_state, quit_state;
  logic iter_start_block, iter_end_block, quit_block;
  logic iter_start_enable, iter_end_enable, quit_enable;
  logic loop_start, loop_ready, loop_done, loop_continue, quit_at_end;
  logic ap_start, ap_ready, ap_done, ap_continue, finish;

  logic loop_active, mod_busy, frozen;
  logic [CNT_W-1:0] iter_started, iter_done, loop_invocations, loop_latency;
  logic [CNT_W-1:0] mod_starts, mod_readys, mod_dones, mod_latency;

  modport master (
    output cur_state, iter_start_state, iter_end_state, quit_state,
           iter_start_block, iter_end_block, quit_block,
           iter_start_enable, iter_end_enable, quit_enable,
           loop_start, loop_ready, loop_done, loop_continue, quit_at_end,
           ap_start, ap_ready, ap_done, ap_continue, finish,
    input  loop_active, mod_busy, frozen, iter_started, iter_done, loop_invocations,
           loop_latency, mod_starts, mod_readys, mod_dones, mod_latency
  );

  modport slave (
    input  cur_state, iter_start_state, iter_end_state, quit_state,
           iter_start_block, iter_end_block, quit_block,
           iter_start_enable, iter_end_enable, quit_enable,
           loop_start, loop_ready, loop_done, loop_continue, quit_at_end,
           ap_start, ap_ready, ap_done, ap_continue, finish,
    output loop_active, mod_busy, frozen, iter_started, iter_done, loop_invocations,
           loop_latency, mod_starts, mod_readys, mod_dones, mod_latency
  );
endinterface

// File: rtl/loop_perf_monitor_inv_ctrl.sv
// Invocation open/close tracker for one ap_ctrl-style start/done/continue handshake.
module loop_perf_inv_ctrl
  import loop_perf_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic hold,
  input  logic start,
  input  logic done,
  input  logic cont,
  output logic active,
  output logic open_c,
  output logic close_c
);
  ctrl_state_t state, state_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= CTRL_IDLE;
    else        state <= state_next;
  end

  // A close blocks any start in the same cycle because opens are only taken from IDLE.
  always_comb begin
    state_next = state;
    open_c     = 1'b0;
    close_c    = 1'b0;
    if (!hold) begin
      case (state)
        CTRL_IDLE: begin
          open_c  = start;
          close_c = start & done & cont;
          if (start && !(done && cont)) state_next = CTRL_ACTIVE;
        end
        CTRL_ACTIVE: begin
          close_c = done & cont;
          if (done && cont) state_next = CTRL_IDLE;
        end
        default: state_next = CTRL_IDLE;
      endcase
    end
  end

  assign active = (state == CTRL_ACTIVE);
endmodule

// File: rtl/loop_perf_monitor_sat_counter.sv
// Saturating up-counter; clear and enable together load 1.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);
  logic [W-1:0] base;

  assign base = clear ? '0 : count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || enable) begin
      count <= (enable && (base != '1)) ? base + W'(1) : base;
    end
  end
endmodule

// File: rtl/loop_perf_monitor.sv
// Passive monitor for one HLS pipelined loop and its enclosing module handshake.
module loop_perf_monitor
  import loop_perf_pkg::*;
#(
  parameter int unsigned STATE_W = 32,
  parameter int unsigned CNT_W   = 32
) (
  input logic                clock,
  input logic                reset,
  loop_perf_monitor_if.slave bus
);
  logic [STATE_W-1:0] cur_state, start_state, end_state, quit_state;
  logic s_ev, e_ev, q_ev, s_cnt;
  logic frozen, hold;
  logic l_act, l_open, l_close, m_busy, m_open, m_close;
  logic [CNT_W-1:0] loop_cyc, mod_cyc, loop_latency, mod_latency;
  logic unused_probe;

  assign cur_state   = bus.cur_state;
  assign start_state = bus.iter_start_state;
  assign end_state   = bus.iter_end_state;
  assign quit_state  = bus.quit_state;
  assign unused_probe = bus.loop_ready;
  assign hold        = frozen;

  assign s_ev = ev_decode(cur_state == start_state, bus.iter_start_enable, bus.iter_start_block);
  assign e_ev = ev_decode(cur_state == end_state, bus.iter_end_enable, bus.iter_end_block);
  assign q_ev = ev_decode(cur_state == quit_state, bus.quit_enable, bus.quit_block);
  // With exit at the start stage, the start that coincides with quit is the exit test, not an iteration.
  assign s_cnt = s_ev & ~(~bus.quit_at_end & q_ev);

  loop_perf_inv_ctrl u_loop_ctrl (
    .clock(clock), .reset(reset), .hold(hold),
    .start(bus.loop_start), .done(bus.loop_done), .cont(bus.loop_continue),
    .active(l_act), .open_c(l_open), .close_c(l_close)
  );

  loop_perf_inv_ctrl u_mod_ctrl (
    .clock(clock), .reset(reset), .hold(hold),
    .start(bus.ap_start), .done(bus.ap_done), .cont(bus.ap_continue),
    .active(m_busy), .open_c(m_open), .close_c(m_close)
  );

  sat_counter #(.W(CNT_W)) u_iter_started (
    .clock(clock), .reset(reset), .clear(l_open),
    .enable(l_act & s_cnt & ~hold), .count(bus.iter_started)
  );
  sat_counter #(.W(CNT_W)) u_iter_done (
    .clock(clock), .reset(reset), .clear(l_open),
    .enable(l_act & e_ev & ~hold), .count(bus.iter_done)
  );
  sat_counter #(.W(CNT_W)) u_loop_cyc (
    .clock(clock), .reset(reset), .clear(l_open),
    .enable(l_open | (l_act & ~hold)), .count(loop_cyc)
  );
  sat_counter #(.W(CNT_W)) u_loop_inv (
    .clock(clock), .reset(reset), .clear(1'b0),
    .enable(l_close), .count(bus.loop_invocations)
  );
  sat_counter #(.W(CNT_W)) u_mod_starts (
    .clock(clock), .reset(reset), .clear(1'b0),
    .enable(m_open), .count(bus.mod_starts)
  );
  sat_counter #(.W(CNT_W)) u_mod_readys (
    .clock(clock), .reset(reset), .clear(1'b0),
    .enable((m_busy | m_open) & bus.ap_ready & ~hold), .count(bus.mod_readys)
  );
  sat_counter #(.W(CNT_W)) u_mod_dones (
    .clock(clock), .reset(reset), .clear(1'b0),
    .enable(m_close), .count(bus.mod_dones)
  );
  sat_counter #(.W(CNT_W)) u_mod_cyc (
    .clock(clock), .reset(reset), .clear(m_open),
    .enable(m_open | (m_busy & ~hold)), .count(mod_cyc)
  );

  // Latency includes the closing cycle; cyc counts cycles already elapsed since the open.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      loop_latency <= '0;
      mod_latency  <= '0;
      frozen       <= 1'b0;
    end else begin
      if (l_close) loop_latency <= l_open ? CNT_W'(1) : ((loop_cyc == '1) ? loop_cyc : loop_cyc + CNT_W'(1));
      if (m_close) mod_latency  <= m_open ? CNT_W'(1) : ((mod_cyc == '1) ? mod_cyc : mod_cyc + CNT_W'(1));
      if (bus.finish) frozen <= 1'b1;
    end
  end

  assign bus.loop_active  = l_act;
  assign bus.mod_busy     = m_busy;
  assign bus.frozen       = frozen;
  assign bus.loop_latency = loop_latency;
  assign bus.mod_latency  = mod_latency;
endmodule

// File: tb/tb_loop_perf_monitor.sv
// Scoreboard bench: a 32-bit and a 4-bit monitor see identical probes, checked against an unbounded count model.
module tb_loop_perf_monitor;
  logic clock;
  logic reset;

  loop_perf_monitor_if #(.STATE_W(32), .CNT_W(32)) bus32 ();
  loop_perf_monitor_if #(.STATE_W(32), .CNT_W(4))  bus4 ();

  loop_perf_monitor #(.STATE_W(32), .CNT_W(32)) u_dut32 (.clock(clock), .reset(reset), .bus(bus32));
  loop_perf_monitor #(.STATE_W(32), .CNT_W(4))  u_dut4  (.clock(clock), .reset(reset), .bus(bus4));

  assign bus4.cur_state         = bus32.cur_state;
  assign bus4.iter_start_state  = bus32.iter_start_state;
  assign bus4.iter_end_state    = bus32.iter_end_state;
  assign bus4.quit_state        = bus32.quit_state;
  assign bus4.iter_start_block  = bus32.iter_start_block;
  assign bus4.iter_end_block    = bus32.iter_end_block;
  assign bus4.quit_block        = bus32.quit_block;
  assign bus4.iter_start_enable = bus32.iter_start_enable;
  assign bus4.iter_end_enable   = bus32.iter_end_enable;
  assign bus4.quit_enable       = bus32.quit_enable;
  assign bus4.loop_start        = bus32.loop_start;
  assign bus4.loop_ready        = bus32.loop_ready;
  assign bus4.loop_done         = bus32.loop_done;
  assign bus4.loop_continue     = bus32.loop_continue;
  assign bus4.quit_at_end       = bus32.quit_at_end;
  assign bus4.ap_start          = bus32.ap_start;
  assign bus4.ap_ready          = bus32.ap_ready;
  assign bus4.ap_done           = bus32.ap_done;
  assign bus4.ap_continue       = bus32.ap_continue;
  assign bus4.finish            = bus32.finish;

  localparam longint MAX32 = 64'd4294967295;
  localparam longint MAX4  = 64'd15;

  typedef struct {
    bit     l_act;
    longint st, dn, inv, lat;
    bit     m_busy;
    longint ms, mr, md, mlat;
    bit     frz;
  } exp_t;

  exp_t   q[$];
  exp_t   mdl;
  longint l_cyc, m_cyc;
  int     checks = 0;
  int     errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all(input string tag, input exp_t e, input longint mx,
                         input longint la, input longint st, input longint dn, input longint inv,
                         input longint lat, input longint mb, input longint ms, input longint mr,
                         input longint md, input longint mlat, input longint frz);
    check({tag, ".loop_active"}, la, longint'(e.l_act));
    check({tag, ".iter_started"}, st, sat(e.st, mx));
    check({tag, ".iter_done"}, dn, sat(e.dn, mx));
    check({tag, ".loop_invocations"}, inv, sat(e.inv, mx));
    check({tag, ".loop_latency"}, lat, sat(e.lat, mx));
    check({tag, ".mod_busy"}, mb, longint'(e.m_busy));
    check({tag, ".mod_starts"}, ms, sat(e.ms, mx));
    check({tag, ".mod_readys"}, mr, sat(e.mr, mx));
    check({tag, ".mod_dones"}, md, sat(e.md, mx));
    check({tag, ".mod_latency"}, mlat, sat(e.mlat, mx));
    check({tag, ".frozen"}, frz, longint'(e.frz));
  endtask

  // Monitor: one expected snapshot per clock edge, compared shortly after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp_all("w32", e, MAX32,
                longint'(bus32.loop_active), longint'(bus32.iter_started), longint'(bus32.iter_done),
                longint'(bus32.loop_invocations), longint'(bus32.loop_latency), longint'(bus32.mod_busy),
                longint'(bus32.mod_starts), longint'(bus32.mod_readys), longint'(bus32.mod_dones),
                longint'(bus32.mod_latency), longint'(bus32.frozen));
        cmp_all("w4", e, MAX4,
                longint'(bus4.loop_active), longint'(bus4.iter_started), longint'(bus4.iter_done),
                longint'(bus4.loop_invocations), longint'(bus4.loop_latency), longint'(bus4.mod_busy),
                longint'(bus4.mod_starts), longint'(bus4.mod_readys), longint'(bus4.mod_dones),
                longint'(bus4.mod_latency), longint'(bus4.frozen));
      end
    end
  end

  task automatic tick_begin();
    @(negedge clock);
    reset                   = 1'b1;
    bus32.cur_state         = 32'd0;
    bus32.iter_start_state  = 32'd5;
    bus32.iter_end_state    = 32'd5;
    bus32.quit_state        = 32'd5;
    bus32.iter_start_block  = 1'b0;
    bus32.iter_end_block    = 1'b0;
    bus32.quit_block        = 1'b0;
    bus32.iter_start_enable = 1'b0;
    bus32.iter_end_enable   = 1'b0;
    bus32.quit_enable       = 1'b0;
    bus32.loop_start        = 1'b0;
    bus32.loop_ready        = 1'b0;
    bus32.loop_done         = 1'b0;
    bus32.loop_continue     = 1'b1;
    bus32.quit_at_end       = 1'b1;
    bus32.ap_start          = 1'b0;
    bus32.ap_ready          = 1'b0;
    bus32.ap_done           = 1'b0;
    bus32.ap_continue       = 1'b1;
    bus32.finish            = 1'b0;
  endtask

  task automatic randomize_inputs();
    bus32.cur_state         = 32'($urandom_range(0, 3));
    bus32.iter_start_state  = 32'($urandom_range(0, 3));
    bus32.iter_end_state    = 32'($urandom_range(0, 3));
    bus32.quit_state        = 32'($urandom_range(0, 3));
    bus32.iter_start_block  = ($urandom_range(0, 3) == 0);
    bus32.iter_end_block    = ($urandom_range(0, 3) == 0);
    bus32.quit_block        = ($urandom_range(0, 3) == 0);
    bus32.iter_start_enable = ($urandom_range(0, 3) != 0);
    bus32.iter_end_enable   = ($urandom_range(0, 3) != 0);
    bus32.quit_enable       = ($urandom_range(0, 1) == 0);
    bus32.loop_start        = ($urandom_range(0, 5) == 0);
    bus32.loop_ready        = ($urandom_range(0, 1) == 0);
    bus32.loop_done         = ($urandom_range(0, 7) == 0);
    bus32.loop_continue     = ($urandom_range(0, 3) != 0);
    bus32.quit_at_end       = ($urandom_range(0, 1) == 0);
    bus32.ap_start          = ($urandom_range(0, 3) == 0);
    bus32.ap_ready          = ($urandom_range(0, 2) == 0);
    bus32.ap_done           = ($urandom_range(0, 9) == 0);
    bus32.ap_continue       = ($urandom_range(0, 3) != 0);
  endtask

  // Reference model: invocations counted as whole-number quantities, saturation applied only at compare time.
  task automatic commit();
    bit s_ev, e_ev, q_ev, lo, lc, mo, mc;
    if (!reset) begin
      mdl   = '{default: 0};
      l_cyc = 0;
      m_cyc = 0;
    end else if (!mdl.frz) begin
      s_ev = (bus32.cur_state == bus32.iter_start_state) && bus32.iter_start_enable && !bus32.iter_start_block;
      e_ev = (bus32.cur_state == bus32.iter_end_state) && bus32.iter_end_enable && !bus32.iter_end_block;
      q_ev = (bus32.cur_state == bus32.quit_state) && bus32.quit_enable && !bus32.quit_block;

      lo = !mdl.l_act && bus32.loop_start;
      lc = (mdl.l_act || lo) && bus32.loop_done && bus32.loop_continue;
      if (mdl.l_act) begin
        if (s_ev && !(!bus32.quit_at_end && q_ev)) mdl.st++;
        if (e_ev) mdl.dn++;
      end
      if (lo) begin
        mdl.st = 0;
        mdl.dn = 0;
        l_cyc  = 1;
      end else if (mdl.l_act) begin
        l_cyc++;
      end
      if (lc) begin
        mdl.lat = l_cyc;
        mdl.inv++;
      end
      mdl.l_act = (mdl.l_act || lo) && !lc;

      mo = !mdl.m_busy && bus32.ap_start;
      mc = (mdl.m_busy || mo) && bus32.ap_done && bus32.ap_continue;
      if ((mdl.m_busy || mo) && bus32.ap_ready) mdl.mr++;
      if (mo) begin
        mdl.ms++;
        m_cyc = 1;
      end else if (mdl.m_busy) begin
        m_cyc++;
      end
      if (mc) begin
        mdl.mlat = m_cyc;
        mdl.md++;
      end
      mdl.m_busy = (mdl.m_busy || mo) && !mc;

      mdl.frz = bus32.finish;
    end
    q.push_back(mdl);
  endtask

  initial begin
    reset = 1'b0;
    mdl   = '{default: 0};
    l_cyc = 0;
    m_cyc = 0;

    // Reset held with random probes, then idle after release.
    for (int c = 0; c < 6; c++) begin
      tick_begin(); randomize_inputs(); reset = 1'b0; commit();
    end
    for (int c = 0; c < 3; c++) begin
      tick_begin(); commit();
    end

    // Four iterations, done on cycle 5.
    for (int c = 0; c < 6; c++) begin
      tick_begin();
      if (c == 0) bus32.loop_start = 1'b1;
      if (c >= 1 && c <= 4) begin
        bus32.cur_state = 32'd5; bus32.iter_start_enable = 1'b1; bus32.iter_end_enable = 1'b1;
      end
      if (c == 5) bus32.loop_done = 1'b1;
      commit();
    end
    tick_begin();
    check("basic.iter_started", longint'(bus32.iter_started), 4);
    check("basic.iter_done", longint'(bus32.iter_done), 4);
    check("basic.loop_latency", longint'(bus32.loop_latency), 6);
    check("basic.loop_invocations", longint'(bus32.loop_invocations), 1);
    commit();

    // Three stalled cycles mid-loop.
    for (int c = 0; c < 9; c++) begin
      tick_begin();
      if (c == 0) bus32.loop_start = 1'b1;
      if (c >= 1 && c <= 7) begin
        bus32.cur_state = 32'd5; bus32.iter_start_enable = 1'b1; bus32.iter_end_enable = 1'b1;
      end
      if (c >= 3 && c <= 5) begin
        bus32.iter_start_block = 1'b1; bus32.iter_end_block = 1'b1;
      end
      if (c == 8) bus32.loop_done = 1'b1;
      commit();
    end
    tick_begin();
    check("stall.iter_started", longint'(bus32.iter_started), 4);
    check("stall.iter_done", longint'(bus32.iter_done), 4);
    check("stall.loop_latency", longint'(bus32.loop_latency), 9);
    commit();

    // Exit at start stage: fifth start coincides with quit.
    for (int c = 0; c < 7; c++) begin
      tick_begin();
      bus32.quit_at_end = 1'b0;
      if (c == 0) bus32.loop_start = 1'b1;
      if (c >= 1 && c <= 5) begin
        bus32.cur_state = 32'd5; bus32.iter_start_enable = 1'b1;
      end
      if (c == 5) bus32.quit_enable = 1'b1;
      if (c == 6) bus32.loop_done = 1'b1;
      commit();
    end
    tick_begin();
    check("quit.iter_started", longint'(bus32.iter_started), 4);
    check("quit.loop_invocations", longint'(bus32.loop_invocations), 3);
    commit();

    // ap_start held; done on cycles 2 and 6.
    for (int c = 0; c < 7; c++) begin
      tick_begin();
      bus32.ap_start = 1'b1;
      if (c == 2 || c == 6) begin
        bus32.ap_done = 1'b1; bus32.ap_ready = 1'b1;
      end
      commit();
    end
    tick_begin();
    check("mod.mod_dones", longint'(bus32.mod_dones), 2);
    check("mod.mod_starts", longint'(bus32.mod_starts), 2);
    check("mod.mod_latency", longint'(bus32.mod_latency), 4);
    check("mod.mod_readys", longint'(bus32.mod_readys), 2);
    commit();

    // Twenty starts saturate the narrow counters.
    for (int c = 0; c < 22; c++) begin
      tick_begin();
      if (c == 0) bus32.loop_start = 1'b1;
      if (c >= 1 && c <= 20) begin
        bus32.cur_state = 32'd5; bus32.iter_start_enable = 1'b1;
      end
      if (c == 21) bus32.loop_done = 1'b1;
      commit();
    end
    tick_begin();
    check("sat.w4.iter_started", longint'(bus4.iter_started), 15);
    check("sat.w4.loop_latency", longint'(bus4.loop_latency), 15);
    check("sat.w32.iter_started", longint'(bus32.iter_started), 20);
    check("sat.w32.loop_latency", longint'(bus32.loop_latency), 22);
    commit();

    // Random traffic with occasional mid-invocation resets.
    for (int c = 0; c < 2500; c++) begin
      tick_begin();
      randomize_inputs();
      if ($urandom_range(0, 299) == 0) reset = 1'b0;
      commit();
    end

    // Freeze, then keep stimulating.
    tick_begin(); randomize_inputs(); bus32.finish = 1'b1; commit();
    for (int c = 0; c < 40; c++) begin
      tick_begin(); randomize_inputs(); commit();
    end
    tick_begin();
    check("freeze.frozen", longint'(bus32.frozen), 1);
    commit();

    @(posedge clock);
    #5;
    check("scoreboard.drained", longint'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
